alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 40 ++++
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue_decode.sv | 76 +++++++
 rtl/alu_issue.sv | 94 +++++++++
 tb/tb_alu_issue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared ALU control encodings, MIPS field constants and issue entry types
package alu_issue_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] BONUS_DEFAULT = 3'b000;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  alu_ctrl;
    logic [2:0]  bonus;
    logic        illegal;
  } issue_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction-in / ALU-operand-out handshake bundle
interface alu_issue_if #(
  parameter int CNT_W = 16
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_opcode;
  logic [5:0]       in_funct;
  logic [31:0]      in_rs_data;
  logic [31:0]      in_rt_data;
  logic [15:0]      in_imm;
  logic [2:0]       in_cmp_sel;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      src1;
  logic [31:0]      src2;
  logic [3:0]       ALU_control;
  logic [2:0]       bonus_control;
  logic             out_illegal;
  logic [CNT_W-1:0] issue_cnt;

  modport master (
    output flush, in_valid, in_opcode, in_funct, in_rs_data, in_rt_data, in_imm, in_cmp_sel,
    output out_ready,
    input  in_ready, out_valid, src1, src2, ALU_control, bonus_control, out_illegal, issue_cnt
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_funct, in_rs_data, in_rt_data, in_imm, in_cmp_sel,
    input  out_ready,
    output in_ready, out_valid, src1, src2, ALU_control, bonus_control, out_illegal, issue_cnt
  );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational MIPS opcode/funct to ALU operand/control decode
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  input  logic [31:0]  i_rs_data,
  input  logic [31:0]  i_rt_data,
  input  logic [15:0]  i_imm,
  input  logic [2:0]   i_cmp_sel,
  output issue_entry_t o_entry
);
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;

  assign w_imm_sext = {{16{i_imm[15]}}, i_imm};
  assign w_imm_zext = {16'h0000, i_imm};

  always_comb begin
    // Unsupported encodings fall through as a harmless ADD of zeros flagged illegal
    o_entry.src1     = 32'h0;
    o_entry.src2     = 32'h0;
    o_entry.alu_ctrl = ALU_ADD;
    o_entry.bonus    = BONUS_DEFAULT;
    o_entry.illegal  = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        o_entry.src1    = i_rs_data;
        o_entry.src2    = i_rt_data;
        o_entry.illegal = 1'b0;
        case (i_funct)
          FN_AND: o_entry.alu_ctrl = ALU_AND;
          FN_OR:  o_entry.alu_ctrl = ALU_OR;
          FN_ADD: o_entry.alu_ctrl = ALU_ADD;
          FN_SUB: o_entry.alu_ctrl = ALU_SUB;
          FN_NOR: o_entry.alu_ctrl = ALU_NOR;
          FN_SLT: begin
            o_entry.alu_ctrl = ALU_SLT;
            o_entry.bonus    = i_cmp_sel;
          end
          default: begin
            o_entry.src1    = 32'h0;
            o_entry.src2    = 32'h0;
            o_entry.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        o_entry.src1     = i_rs_data;
        o_entry.src2     = w_imm_sext;
        o_entry.alu_ctrl = ALU_ADD;
        o_entry.illegal  = 1'b0;
      end
      OP_SLTI: begin
        o_entry.src1     = i_rs_data;
        o_entry.src2     = w_imm_sext;
        o_entry.alu_ctrl = ALU_SLT;
        o_entry.bonus    = i_cmp_sel;
        o_entry.illegal  = 1'b0;
      end
      OP_ANDI: begin
        o_entry.src1     = i_rs_data;
        o_entry.src2     = w_imm_zext;
        o_entry.alu_ctrl = ALU_AND;
        o_entry.illegal  = 1'b0;
      end
      OP_ORI: begin
        o_entry.src1     = i_rs_data;
        o_entry.src2     = w_imm_zext;
        o_entry.alu_ctrl = ALU_OR;
        o_entry.illegal  = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode stage feeding a 2-entry skid queue toward the ALU, with issue counter
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_issue_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  q_state_t         r_state;
  issue_entry_t     r_head;
  issue_entry_t     r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  issue_entry_t     w_dec;
  logic             w_accept;
  logic             w_retire;

  alu_decode u_decode (
    .i_opcode  (bus.in_opcode),
    .i_funct   (bus.in_funct),
    .i_rs_data (bus.in_rs_data),
    .i_rt_data (bus.in_rt_data),
    .i_imm     (bus.in_imm),
    .i_cmp_sel (bus.in_cmp_sel),
    .o_entry   (w_dec)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_retire = r_out_valid & bus.out_ready;

  // Handshake flags are registered alongside the state so in_ready never sees out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= Q_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_retire) r_cnt <= r_cnt + CNT_ONE;
      if (bus.flush) begin
        r_state     <= Q_EMPTY;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          Q_EMPTY: if (w_accept) begin
            r_head      <= w_dec;
            r_state     <= Q_ONE;
            r_out_valid <= 1'b1;
          end
          Q_ONE: begin
            if (w_accept && w_retire) begin
              r_head <= w_dec;
            end else if (w_accept) begin
              r_skid     <= w_dec;
              r_state    <= Q_FULL;
              r_in_ready <= 1'b0;
            end else if (w_retire) begin
              r_state     <= Q_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
          Q_FULL: if (w_retire) begin
            r_head     <= r_skid;
            r_state    <= Q_ONE;
            r_in_ready <= 1'b1;
          end
          default: begin
            r_state     <= Q_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.src1          = r_head.src1;
  assign bus.src2          = r_head.src2;
  assign bus.ALU_control   = r_head.alu_ctrl;
  assign bus.bonus_control = r_head.bonus;
  assign bus.out_illegal   = r_head.illegal;
  assign bus.issue_cnt     = r_cnt;
endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed vector and sequence bench for alu_issue
module tb_alu_issue;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_issue_if #(.CNT_W(16)) bus ();

  alu_issue #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [2:0]  cmp;
    logic [31:0] e_src1;
    logic [31:0] e_src2;
    logic [3:0]  e_ctrl;
    logic [2:0]  e_bonus;
    logic        e_ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic [2:0] cmp);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_funct   = fn;
    bus.in_rs_data = rs;
    bus.in_rt_data = rt;
    bus.in_imm     = imm;
    bus.in_cmp_sel = cmp;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_src1"},      bus.src1, 32'd0);
    chk({tag, "_src2"},      bus.src2, 32'd0);
    chk({tag, "_ctrl"},      32'(bus.ALU_control), 32'd0);
    chk({tag, "_bonus"},     32'(bus.bonus_control), 32'd0);
    chk({tag, "_illegal"},   32'(bus.out_illegal), 32'd0);
    chk({tag, "_cnt"},       32'(bus.issue_cnt), 32'd0);
  endtask

  initial begin
    int n;
    int budget;
    checks = 0;
    errors = 0;

    //            op     fn     rs            rt            imm      cmp     src1          src2          ctrl     bonus   ill
    vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 3'b000, 32'd5,        32'd7,        4'b0010, 3'b000, 1'b0};
    vecs[1]  = '{6'h08, 6'h00, 32'd3,        32'd9,        16'hFFFF, 3'b111, 32'd3,        32'hFFFFFFFF, 4'b0010, 3'b000, 1'b0};
    vecs[2]  = '{6'h0D, 6'h00, 32'h12345678, 32'd0,        16'hFFFF, 3'b000, 32'h12345678, 32'h0000FFFF, 4'b0001, 3'b000, 1'b0};
    vecs[3]  = '{6'h0A, 6'h00, 32'd1,        32'd0,        16'h8000, 3'b101, 32'd1,        32'hFFFF8000, 4'b0111, 3'b101, 1'b0};
    vecs[4]  = '{6'h3F, 6'h20, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1234, 3'b111, 32'd0,        32'd0,        4'b0010, 3'b000, 1'b1};
    vecs[5]  = '{6'h00, 6'h22, 32'd100,      32'd40,       16'h0000, 3'b010, 32'd100,      32'd40,       4'b0110, 3'b000, 1'b0};
    vecs[6]  = '{6'h00, 6'h2A, 32'hFFFFFFFE, 32'd2,        16'h0000, 3'b011, 32'hFFFFFFFE, 32'd2,        4'b0111, 3'b011, 1'b0};
    vecs[7]  = '{6'h00, 6'h27, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0000, 3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b1100, 3'b000, 1'b0};
    vecs[8]  = '{6'h00, 6'h24, 32'hAAAA5555, 32'h0000FFFF, 16'h0000, 3'b000, 32'hAAAA5555, 32'h0000FFFF, 4'b0000, 3'b000, 1'b0};
    vecs[9]  = '{6'h00, 6'h25, 32'h11111111, 32'h22222222, 16'h0000, 3'b000, 32'h11111111, 32'h22222222, 4'b0001, 3'b000, 1'b0};
    vecs[10] = '{6'h0C, 6'h00, 32'h7FFFFFFF, 32'd0,        16'h8001, 3'b110, 32'h7FFFFFFF, 32'h00008001, 4'b0000, 3'b000, 1'b0};
    vecs[11] = '{6'h00, 6'h21, 32'd9,        32'd9,        16'h0000, 3'b001, 32'd0,        32'd0,        4'b0010, 3'b000, 1'b1};

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    offer(6'h00, 6'h20, 32'd0, 32'd0, 16'h0, 3'b0);
    bus.in_valid = 1'b0;
    #12;
    chk_reset_outputs("reset");
    step();
    rst_n = 1'b1;

    // Each vector: accept, present next cycle, retire on the following edge
    for (int i = 0; i < 12; i++) begin
      offer(vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].cmp);
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_src1", i), bus.src1, vecs[i].e_src1);
      chk($sformatf("v%0d_src2", i), bus.src2, vecs[i].e_src2);
      chk($sformatf("v%0d_ctrl", i), 32'(bus.ALU_control), 32'(vecs[i].e_ctrl));
      chk($sformatf("v%0d_bonus", i), 32'(bus.bonus_control), 32'(vecs[i].e_bonus));
      chk($sformatf("v%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].e_ill));
      step();
      chk($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d_cnt", i), 32'(bus.issue_cnt), 32'(i + 1));
    end

    // Back-pressure: A, B, C offered with consumer stalled
    bus.out_ready = 1'b0;
    offer(6'h00, 6'h20, 32'hA, 32'd0, 16'h0, 3'b0);
    step();
    chk("bp_ready_after_a", 32'(bus.in_ready), 32'd1);
    offer(6'h00, 6'h20, 32'hB, 32'd0, 16'h0, 3'b0);
    step();
    chk("bp_ready_after_b", 32'(bus.in_ready), 32'd0);
    chk("bp_head_a", bus.src1, 32'hA);
    offer(6'h00, 6'h20, 32'hC, 32'd0, 16'h0, 3'b0);
    step();
    chk("bp_ready_hold", 32'(bus.in_ready), 32'd0);
    chk("bp_head_a_stable", bus.src1, 32'hA);
    chk("bp_cnt_hold", 32'(bus.issue_cnt), 32'd12);
    bus.out_ready = 1'b1;
    step();
    chk("bp_head_b", bus.src1, 32'hB);
    chk("bp_ready_again", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_head_c", bus.src1, 32'hC);
    chk("bp_valid_c", 32'(bus.out_valid), 32'd1);
    step();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_cnt", 32'(bus.issue_cnt), 32'd15);

    // Flush while FULL with a new offer: the offer is dropped
    bus.out_ready = 1'b0;
    offer(6'h00, 6'h20, 32'h1, 32'd0, 16'h0, 3'b0);
    step();
    offer(6'h00, 6'h20, 32'h2, 32'd0, 16'h0, 3'b0);
    step();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    bus.flush = 1'b1;
    offer(6'h00, 6'h20, 32'h3, 32'd0, 16'h0, 3'b0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("fl_not_accepted", 32'(bus.out_valid), 32'd0);
    chk("fl_cnt", 32'(bus.issue_cnt), 32'd15);

    // A retire coinciding with flush is still counted
    offer(6'h00, 6'h20, 32'h4, 32'd0, 16'h0, 3'b0);
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flr_cnt", 32'(bus.issue_cnt), 32'd16);
    chk("flr_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-operation while FULL
    bus.out_ready = 1'b0;
    offer(6'h0D, 6'h00, 32'h55, 32'd0, 16'h1234, 3'b0);
    step();
    offer(6'h0A, 6'h00, 32'h66, 32'd0, 16'h0001, 3'b101);
    step();
    bus.in_valid = 1'b0;
    chk("ar_full", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    rst_n = 1'b1;
    step();
    chk("ar_no_survivor", 32'(bus.out_valid), 32'd0);

    // Counter wrap: 0xFFFF streamed retires, then one more
    bus.out_ready = 1'b1;
    offer(6'h00, 6'h20, 32'h7, 32'd1, 16'h0, 3'b0);
    n = 0;
    budget = 0;
    while (n < 65535 && budget < 70000) begin
      if (bus.out_valid) n++;
      step();
      budget++;
    end
    chk("wrap_budget", 32'(n), 32'd65535);
    chk("wrap_preload", 32'(bus.issue_cnt), 32'h0000FFFF);
    bus.in_valid = 1'b0;
    step();
    chk("wrap_zero", 32'(bus.issue_cnt), 32'd0);
    chk("wrap_empty", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
